// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between an instruction-side line reader and a data-side
// line reader/writer, moving whole BURST-word lines with round-robin arbitration.
module bram_port_arbiter #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int BURST  = 4,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_rvalid,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_wready,
   output logic              d_rvalid,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_regce,
   output logic              mem_rst,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [2:0]        o_dbg_state
);

   // Handshake: a requester raises req with addr/we and holds req until its done
   // pulse; rvalid marks rdata as its word, wready means d_wdata is consumed now.

   localparam int LB = $clog2(BURST);
   localparam logic [LB-1:0]     BEAT_LAST = LB'(BURST - 1);
   localparam logic [LB-1:0]     BEAT_ONE  = LB'(1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST - 1);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR, DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [LB-1:0]     r_beat;
   logic              r_grant_d;
   logic              r_last_d;
   logic [ADDR_W-1:0] r_base;
   logic [RD_LAT-1:0] r_vpipe;
   logic [RD_LAT-1:0] r_lpipe;

   logic              w_any_req;
   logic              w_grant_d;
   logic [ADDR_W-1:0] w_req_addr;
   logic              w_last_beat;
   logic              w_issue;
   logic              w_rvalid;
   logic              w_rlast;

   assign w_any_req   = i_req | d_req;
   // D wins unless I is also asking and D had the previous grant.
   assign w_grant_d   = d_req & (~i_req | ~r_last_d);
   assign w_req_addr  = w_grant_d ? d_addr : i_addr;
   assign w_last_beat = (r_beat == BEAT_LAST);
   assign w_rvalid    = r_vpipe[RD_LAT-1];
   assign w_rlast     = r_lpipe[RD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_grant_d <= 1'b0;
         r_last_d  <= 1'b0;
         r_base    <= '0;
         r_vpipe   <= '0;
         r_lpipe   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any_req) begin
            r_grant_d <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_base    <= w_req_addr & LINE_MASK;
            r_beat    <= '0;
         end else if (r_state == RD_ISSUE || r_state == WR) begin
            r_beat <= r_beat + BEAT_ONE;
         end
         // Issue tags travel alongside the BRAM read pipeline.
         r_vpipe[0] <= w_issue;
         r_lpipe[0] <= w_issue & w_last_beat;
         for (int k = 1; k < RD_LAT; k++) begin
            r_vpipe[k] <= r_vpipe[k-1];
            r_lpipe[k] <= r_lpipe[k-1];
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_regce = 1'b0;
      d_wready  = 1'b0;
      w_issue   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) w_next = (w_grant_d && d_we) ? WR : RD_ISSUE;
         end
         RD_ISSUE: begin
            mem_en    = 1'b1;
            mem_regce = 1'b1;
            w_issue   = 1'b1;
            if (w_last_beat) w_next = RD_DRAIN;
         end
         RD_DRAIN: begin
            mem_regce = 1'b1;
            if (w_rvalid && w_rlast) w_next = IDLE;
         end
         WR: begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            d_wready = 1'b1;
            if (w_last_beat) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign mem_addr    = mem_en ? ((r_base & LINE_MASK) | {{(ADDR_W-LB){1'b0}}, r_beat}) : '0;
   assign mem_din     = (r_state == WR) ? d_wdata : '0;
   assign mem_rst     = ~rst_n;
   assign rdata       = mem_dout;
   assign i_rvalid    = w_rvalid & ~r_grant_d;
   assign d_rvalid    = w_rvalid & r_grant_d;
   assign i_done      = w_rvalid & w_rlast & ~r_grant_d;
   assign d_done      = (w_rvalid & w_rlast & r_grant_d) | (r_state == DONE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model with output register, reactive requesters,
// and a transaction-level schedule model producing the expected event trace.
module tb_bram_port_arbiter;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int BURST  = 4;
   localparam int RD_LAT = 2;
   localparam int EW     = 16 + 4 + ADDR_W + DATA_W;

   localparam int K_RD = 1, K_WR = 2, K_IRV = 3, K_DRV = 4, K_IDONE = 5;
   localparam int K_DDONE = 6, K_WRDY = 7, K_REGCE = 8, K_MRST = 9, K_STRAY = 10;

   typedef struct packed {
      logic                         drop;
      logic                         we;
      logic [ADDR_W-1:0]            addr;
      logic [BURST-1:0][DATA_W-1:0] words;
   } txn_t;

   logic              clk, rst_n;
   logic              i_req, i_rvalid, i_done;
   logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
   logic              d_req, d_we, d_wready, d_rvalid, d_done;
   logic [DATA_W-1:0] d_wdata, rdata, mem_din, mem_dout;
   logic              mem_en, mem_we, mem_regce, mem_rst;
   logic [2:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   bit m_last_d;
   logic [DATA_W-1:0] ref_mem [0:1023];
   txn_t iq[$];
   txn_t dq[$];
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] obs_q[$];

   bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wready(d_wready), .d_rvalid(d_rvalid), .d_done(d_done),
      .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en),
      .mem_we(mem_we), .mem_regce(mem_regce), .mem_rst(mem_rst),
      .mem_dout(mem_dout), .o_dbg_state(dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] init_val(input int a);
      return DATA_W'(a) * 32'h9E3779B1 ^ 32'h5A5A5A5A;
   endfunction

   // BRAM with registered output (read latency 2)
   logic [DATA_W-1:0] bram [0:1023];
   bit                bram_wr [0:1023];
   logic [DATA_W-1:0] b_s1, b_s2;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            bram[mem_addr[9:0]]    <= mem_din;
            bram_wr[mem_addr[9:0]] <= 1'b1;
         end else begin
            b_s1 <= bram_wr[mem_addr[9:0]] ? bram[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
         end
      end
   end
   always @(posedge clk or posedge mem_rst) begin
      if (mem_rst) b_s2 <= '0;
      else if (mem_regce) b_s2 <= b_s1;
   end
   assign mem_dout = b_s2;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] ev(input int c, input int kind,
                                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      return {16'(c), 4'(kind), a, d};
   endfunction

   function automatic txn_t mk_txn(input logic [ADDR_W-1:0] a, input logic we, input logic drop,
                                   input logic [DATA_W-1:0] w0);
      txn_t t;
      t.addr = a;
      t.we   = we;
      t.drop = drop;
      for (int k = 0; k < BURST; k++) t.words[k] = w0 + DATA_W'(k);
      return t;
   endfunction

   function automatic txn_t rand_txn(input bit is_d);
      txn_t t;
      t.addr = ADDR_W'($urandom_range(0, 1023));
      t.we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      t.drop = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < BURST; k++) t.words[k] = $urandom;
      return t;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".mem_en"},    128'(mem_en),    128'(0));
      chk({tag, ".mem_we"},    128'(mem_we),    128'(0));
      chk({tag, ".mem_regce"}, 128'(mem_regce), 128'(0));
      chk({tag, ".mem_rst"},   128'(mem_rst),   128'(1));
      chk({tag, ".mem_addr"},  128'(mem_addr),  128'(0));
      chk({tag, ".mem_din"},   128'(mem_din),   128'(0));
      chk({tag, ".i_rvalid"},  128'(i_rvalid),  128'(0));
      chk({tag, ".i_done"},    128'(i_done),    128'(0));
      chk({tag, ".d_rvalid"},  128'(d_rvalid),  128'(0));
      chk({tag, ".d_wready"},  128'(d_wready),  128'(0));
      chk({tag, ".d_done"},    128'(d_done),    128'(0));
      chk({tag, ".rdata"},     128'(rdata),     128'(0));
      chk({tag, ".state"},     128'(dbg_state), 128'(0));
   endtask

   // Runs the transactions queued in iq/dq, all requested from cycle 0, and
   // compares the observed event trace with the schedule derived from the rules.
   task automatic run_scen(input string tag);
      txn_t mi[$];
      txn_t md[$];
      txn_t tx;
      int t, ni, nd, end_c, wr_idx, idx, n;
      bit hi, hd, sd, i_seen, d_seen;
      logic [ADDR_W-1:0] base;
      exp_q.delete();
      obs_q.delete();
      mi = iq;
      md = dq;
      t = 0; ni = 0; nd = 0;
      while (ni < mi.size() || nd < md.size()) begin
         hi = (ni < mi.size());
         hd = (nd < md.size());
         sd = hd && (!hi || !m_last_d);
         m_last_d = sd;
         if (sd) begin tx = md[nd]; nd++; end
         else    begin tx = mi[ni]; ni++; end
         base = tx.addr & ~ADDR_W'(BURST - 1);
         if (sd && tx.we) begin
            for (int k = 0; k < BURST; k++) begin
               idx = int'(base[9:0]) + k;
               exp_q.push_back(ev(t + 1 + k, K_WR, base + ADDR_W'(k), tx.words[k]));
               exp_q.push_back(ev(t + 1 + k, K_WRDY, '0, '0));
               ref_mem[idx] = tx.words[k];
            end
            exp_q.push_back(ev(t + BURST + 1, K_DDONE, '0, '0));
            t = t + BURST + 2;
         end else begin
            for (int k = 0; k < BURST; k++) begin
               idx = int'(base[9:0]) + k;
               exp_q.push_back(ev(t + 1 + k, K_RD, base + ADDR_W'(k), '0));
               exp_q.push_back(ev(t + 1 + k + RD_LAT, sd ? K_DRV : K_IRV, '0, ref_mem[idx]));
            end
            for (int c = t + 1; c <= t + BURST + RD_LAT; c++) exp_q.push_back(ev(c, K_REGCE, '0, '0));
            exp_q.push_back(ev(t + BURST + RD_LAT, sd ? K_DDONE : K_IDONE, '0, '0));
            t = t + BURST + RD_LAT + 1;
         end
      end
      end_c = t + 2;

      i_seen = 0; d_seen = 0; wr_idx = 0;
      for (int c = 0; c <= end_c; c++) begin
         @(negedge clk);
         #1;
         i_req   = (iq.size() > 0) && !(i_seen && iq[0].drop);
         i_addr  = (iq.size() > 0 && !i_seen) ? iq[0].addr : ADDR_W'($urandom);
         d_req   = (dq.size() > 0) && !(d_seen && dq[0].drop);
         d_addr  = (dq.size() > 0 && !d_seen) ? dq[0].addr : ADDR_W'($urandom);
         d_we    = (dq.size() > 0 && !d_seen) ? dq[0].we : 1'($urandom);
         d_wdata = (dq.size() > 0 && wr_idx < BURST) ? dq[0].words[wr_idx] : $urandom;
         #1;
         if (mem_en) obs_q.push_back(ev(c, mem_we ? K_WR : K_RD, mem_addr, mem_we ? mem_din : '0));
         if (mem_we && !mem_en) obs_q.push_back(ev(c, K_STRAY, mem_addr, mem_din));
         if (i_rvalid)  obs_q.push_back(ev(c, K_IRV, '0, rdata));
         if (d_rvalid)  obs_q.push_back(ev(c, K_DRV, '0, rdata));
         if (i_done)    obs_q.push_back(ev(c, K_IDONE, '0, '0));
         if (d_done)    obs_q.push_back(ev(c, K_DDONE, '0, '0));
         if (d_wready)  obs_q.push_back(ev(c, K_WRDY, '0, '0));
         if (mem_regce) obs_q.push_back(ev(c, K_REGCE, '0, '0));
         if (mem_rst)   obs_q.push_back(ev(c, K_MRST, '0, '0));
         if (i_rvalid) i_seen = 1;
         if (d_rvalid || d_wready) d_seen = 1;
         if (d_wready) wr_idx++;
         if (i_done && iq.size() > 0) begin void'(iq.pop_front()); i_seen = 0; end
         if (d_done && dq.size() > 0) begin void'(dq.pop_front()); d_seen = 0; wr_idx = 0; end
      end
      i_req = 1'b0;
      d_req = 1'b0;

      chk({tag, ".i_pending"}, 128'(iq.size()), 128'(0));
      chk({tag, ".d_pending"}, 128'(dq.size()), 128'(0));
      iq.delete();
      dq.delete();
      exp_q.sort();
      obs_q.sort();
      chk({tag, ".events"}, 128'(obs_q.size()), 128'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s.ev%0d", tag, i), 128'(obs_q[i]), 128'(exp_q[i]));
   endtask

   initial begin
      txn_t tx;
      int ni, nd;
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      m_last_d = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle.mem_rst", 128'(mem_rst), 128'(0));

      // both sides request together after reset: D, then I, then D
      dq.push_back(mk_txn(30'h200, 1'b0, 1'b0, '0));
      dq.push_back(mk_txn(30'h301, 1'b1, 1'b0, 32'h1000));
      iq.push_back(mk_txn(30'h182, 1'b0, 1'b0, '0));
      run_scen("rr");

      // I read of a misaligned address
      iq.push_back(mk_txn(30'h105, 1'b0, 1'b0, '0));
      run_scen("iread");

      // D write-back of a line
      dq.push_back(mk_txn(30'h040, 1'b1, 1'b0, 32'hA0));
      run_scen("dwrite");

      // D refill with request dropped mid-burst
      dq.push_back(mk_txn(30'h10F, 1'b0, 1'b1, '0));
      run_scen("drop");

      // read back the written line through the I side
      iq.push_back(mk_txn(30'h043, 1'b0, 1'b0, '0));
      run_scen("rdback");

      for (int s = 0; s < 8; s++) begin
         ni = $urandom_range(0, 2);
         nd = $urandom_range(0, 2);
         if (ni + nd == 0) nd = 1;
         for (int i = 0; i < ni; i++) iq.push_back(rand_txn(1'b0));
         for (int i = 0; i < nd; i++) dq.push_back(rand_txn(1'b1));
         run_scen($sformatf("rand%0d", s));
      end

      // reset on the second drain cycle of an I read
      tx = mk_txn(30'h244, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      i_req  = 1'b1;
      i_addr = tx.addr;
      repeat (6) @(negedge clk);
      #1;
      chk("mid.pre_i_rvalid", 128'(i_rvalid), 128'(1));
      chk("mid.pre_rdata", 128'(rdata), 128'(ref_mem[16'h247]));
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      chk_reset_outputs("mid");
      @(negedge clk);
      #1;
      chk("mid.hold_i_done", 128'(i_done), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      m_last_d = 1'b0;

      // service after reset, contents preserved
      iq.push_back(mk_txn(30'h041, 1'b0, 1'b0, '0));
      run_scen("post_rst");
      dq.push_back(mk_txn(30'h3FE, 1'b0, 1'b0, '0));
      iq.push_back(mk_txn(30'h3FD, 1'b0, 1'b0, '0));
      run_scen("post_rst_rr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 30: word-address width of the shared BRAM port.
REQ-002 The block SHALL have parameter DATA_W, default 32: data word width.
REQ-003 The block SHALL have parameter BURST, default 4: words per cache-line transfer; power of two, 2..16.
REQ-004 The block SHALL have parameter RD_LAT, default 2: BRAM read latency in cycles from mem_en to valid mem_dout; legal values 1 or 2.
REQ-005 The block SHALL have the following ports, in this order:
- clk  in  1  sole clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-side line-read request; held until i_done.
- i_addr  in  ADDR_W  instruction-side line address.
- i_rvalid  out  1  rdata carries an I-side word this cycle.
- i_done  out  1  one-cycle pulse: I-side transfer complete.
- d_req  in  1  data-side request; held until d_done.
- d_we  in  1  data-side direction: 1 = line write-back, 0 = line refill.
- d_addr  in  ADDR_W  data-side line address.
- d_wdata  in  DATA_W  current write-back word.
- d_wready  out  1  d_wdata consumed this cycle.
- d_rvalid  out  1  rdata carries a D-side word this cycle.
- d_done  out  1  one-cycle pulse: D-side transfer complete.
- rdata  out  DATA_W  read data shared by both sides; equals mem_dout.
- mem_addr  out  ADDR_W  BRAM port address.
- mem_din  out  DATA_W  BRAM write data.
- mem_en  out  1  BRAM port enable.
- mem_we  out  1  BRAM write enable.
- mem_regce  out  1  BRAM output-register enable.
- mem_rst  out  1  BRAM output-register reset.

Function
REQ-006 The block SHALL own exactly one BRAM port and serialise whole-line transfers from the two requesters onto it.
REQ-007 The FSM SHALL have the states IDLE, RD_ISSUE, RD_DRAIN, WR and DONE.
REQ-008 In IDLE with at least one request, the block SHALL latch the winner, the direction and the base address (low log2(BURST) bits forced to 0), then enter RD_ISSUE or WR on the next edge.
REQ-009 Arbitration SHALL be round-robin: on simultaneous requests the side not granted last wins; the first contention after reset goes to D.
REQ-010 In RD_ISSUE the block SHALL drive mem_en=1 and mem_we=0 for BURST consecutive cycles, with mem_addr = base + beat, beat 0..BURST-1.
REQ-011 At the end of RD_ISSUE the block SHALL enter RD_DRAIN, and stay there until the last word returns.
REQ-012 The read data for each beat SHALL appear on rdata exactly RD_LAT cycles after that beat was issued, with the granted side's rvalid high in the same cycle.
REQ-013 The granted side's done SHALL pulse in the same cycle as its last rvalid, and the FSM SHALL return to IDLE on the next edge.
REQ-014 In WR the block SHALL drive mem_en=1, mem_we=1, mem_din=d_wdata and d_wready=1 for BURST consecutive cycles, with addresses as in REQ-010.
REQ-015 After WR the FSM SHALL enter DONE for one cycle; d_done SHALL pulse in that cycle, followed by IDLE.
REQ-016 The beat counter SHALL wrap modulo BURST, and the address SHALL never carry into bits above log2(BURST).
REQ-017 mem_regce SHALL be 1 from the first read issue through the last rvalid, and 0 otherwise.
REQ-018 mem_rst SHALL be 1 while rst_n=0, and 0 otherwise.
REQ-019 A request dropped mid-transfer SHALL be ignored: the burst completes and done still pulses.
REQ-020 Request and address changes during a transfer SHALL not affect the latched values.
REQ-021 The earliest next grant SHALL be sampled in the IDLE cycle following done.
REQ-022 An I-side request SHALL always be treated as a read.
REQ-023 mem_en SHALL be 0 in IDLE, RD_DRAIN and DONE.
REQ-024 rvalid, wready and done SHALL never be asserted toward the side that is not granted.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the FSM to IDLE and the beat counter to 0.
REQ-026 Asserting rst_n low SHALL immediately force all 1-bit outputs except mem_rst to 0, force mem_addr and mem_din to 0, and set the last-grant state to I (so D wins first).
REQ-027 A reset in mid-transfer SHALL abort the transfer with no done pulse; in-flight read data SHALL be discarded.
REQ-028 The block SHALL leave BRAM contents untouched on reset.

Verification
REQ-029 Read test: I read, i_addr=0x105, BURST=4, RD_LAT=2 -> mem_addr 0x104..0x107 on 4 consecutive cycles; i_rvalid on 4 cycles starting 2 after the first issue; i_done with the 4th.
REQ-030 Write test: D write-back, d_addr=0x40, d_wdata 0xA0..0xA3 -> mem_we=1 at 0x40..0x43 with matching mem_din; d_wready 4 cycles; d_done 1 cycle later.
REQ-031 Round-robin test: i_req and d_req rise together after reset, both held -> D served first, then I, then D; no idle cycle other than IDLE between grants.
REQ-032 Dropped-request test: d_req dropped after beat 1 of a read -> 4 beats still issued, d_done pulses.
REQ-033 Reset test: rst_n low on the 2nd RD_DRAIN cycle -> all outputs 0 in that cycle (mem_rst 1), no done pulse; after release, a new I request is served normally.
